// File: rtl/note_arbiter_pkg.sv
// Shared constants and state encoding for the keyboard front end
// (debounce stage and note arbiter).
package note_arbiter_pkg;

    localparam int DEBOUNCE_TIME = 1_000_000;   // debounce settle time, cycles
    localparam int HOLD_MIN_DEF  = 2_000_000;   // 20 ms at 100 MHz

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ON_EV  = 2'd1,
        PLAY   = 2'd2,
        OFF_EV = 2'd3
    } arb_state_t;

endpackage

// File: rtl/note_arbiter_lowest_set.sv
// Combinational priority encoder: index of the lowest set bit (0 when none set).
module lowest_set #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] x,
    output logic [W-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (x[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/note_arbiter.sv
// Monophonic last-pressed-priority note arbiter with a minimum note duration,
// emitting note-on/note-off events over a valid/ready handshake.
module note_arbiter
    import note_arbiter_pkg::*;
#(
    parameter int NKEYS    = 8,
    parameter int HOLD_MIN = HOLD_MIN_DEF,
    localparam int NW      = $clog2(NKEYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key_level,
    output logic             ev_valid,
    output logic             ev_on,
    output logic [NW-1:0]    ev_note,
    input  logic             ev_ready,
    output logic             active,
    output logic [NW-1:0]    cur_note
);

    localparam int HW = (HOLD_MIN > 1) ? $clog2(HOLD_MIN) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MIN - 1);

    arb_state_t       state;
    logic [NKEYS-1:0] key_q, pend, press, mask, pend_clr, pend_base;
    logic [NW-1:0]    nxt, low_key, low_pend;
    logic             nxt_v;
    logic [HW-1:0]    hold_cnt;
    logic             hold_sat;

    lowest_set #(.N(NKEYS), .W(NW)) u_low_key  (.x(key_level), .idx(low_key));
    lowest_set #(.N(NKEYS), .W(NW)) u_low_pend (.x(pend),      .idx(low_pend));

    assign press    = key_level & ~key_q;
    assign hold_sat = (hold_cnt == HOLD_LAST);

    // Keys already chosen to sound (current, committed next, or about to be
    // loaded from IDLE) never enter pend, so re-presses cause no events.
    always_comb begin
        mask     = '0;
        pend_clr = '0;
        case (state)
            IDLE:    if (|key_level) mask[low_key] = 1'b1;
            OFF_EV: begin
                mask[cur_note] = 1'b1;
                if (nxt_v) mask[nxt] = 1'b1;
            end
            default: mask[cur_note] = 1'b1;
        endcase
        if (state == PLAY && hold_sat && |pend) pend_clr[low_pend] = 1'b1;
    end

    assign pend_base = (state == IDLE) ? '0 : pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= '0;
            pend  <= '0;
        end else begin
            key_q <= key_level;
            pend  <= (pend_base | press) & key_level & ~mask & ~pend_clr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ev_valid <= 1'b0;
            ev_on    <= 1'b0;
            ev_note  <= '0;
            active   <= 1'b0;
            cur_note <= '0;
            nxt      <= '0;
            nxt_v    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|key_level) begin
                        cur_note <= low_key;
                        ev_valid <= 1'b1;
                        ev_on    <= 1'b1;
                        ev_note  <= low_key;
                        state    <= ON_EV;
                    end
                end
                // Entered with ev_valid low after a note-off: offer one cycle later.
                ON_EV: begin
                    if (!ev_valid) begin
                        ev_valid <= 1'b1;
                        ev_on    <= 1'b1;
                        ev_note  <= cur_note;
                    end else if (ev_ready) begin
                        ev_valid <= 1'b0;
                        active   <= 1'b1;
                        hold_cnt <= '0;
                        state    <= PLAY;
                    end
                end
                PLAY: begin
                    if (!hold_sat) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (|pend) begin
                        nxt   <= low_pend;
                        nxt_v <= 1'b1;
                        state <= OFF_EV;
                    end else if (!key_level[cur_note]) begin
                        nxt   <= low_key;
                        nxt_v <= |key_level;
                        state <= OFF_EV;
                    end
                end
                OFF_EV: begin
                    if (!ev_valid) begin
                        ev_valid <= 1'b1;
                        ev_on    <= 1'b0;
                        ev_note  <= cur_note;
                    end else if (ev_ready) begin
                        ev_valid <= 1'b0;
                        active   <= 1'b0;
                        if (nxt_v) begin
                            cur_note <= nxt;
                            state    <= ON_EV;
                        end else begin
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_arbiter.sv
// Directed bench for note_arbiter: cycle-exact vector table plus corner-case sequences.
module tb_note_arbiter;

    localparam int NKEYS = 8;
    localparam int NW    = 3;
    localparam int HOLD  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NKEYS-1:0] key_level = '0;
    logic             ev_ready = 1'b1;
    logic             ev_valid, ev_on, active;
    logic [NW-1:0]    ev_note, cur_note;

    int tests = 0;
    int fails = 0;
    int xfers = 0;

    always #5 clk = ~clk;

    note_arbiter #(.NKEYS(NKEYS), .HOLD_MIN(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_level(key_level),
        .ev_valid (ev_valid),
        .ev_on    (ev_on),
        .ev_note  (ev_note),
        .ev_ready (ev_ready),
        .active   (active),
        .cur_note (cur_note)
    );

    always @(posedge clk) if (!rst && ev_valid && ev_ready) xfers++;

    typedef struct {
        logic [NKEYS-1:0] key;
        logic             rdy;
        logic             v;
        logic             on;
        logic [NW-1:0]    note;
        logic             act;
        logic [NW-1:0]    cur;
    } vec_t;

    vec_t vec [34];

    task automatic chk(input string nm, input int act_v, input int exp_v);
        tests++;
        if (act_v != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act_v, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_level = '0;
        ev_ready = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    // Advance until an event is offered (bounded), then check its content.
    task automatic wait_offer(input logic on, input int note, input string nm);
        int n = 0;
        while (!ev_valid && n < 200) begin
            step(1);
            n++;
        end
        chk({nm, "_offer"}, int'(ev_valid), 1);
        chk({nm, "_on"},    int'(ev_on),    int'(on));
        chk({nm, "_note"},  int'(ev_note),  note);
    endtask

    initial begin
        // key, rdy, v, on, note, act, cur  (outputs after the edge)
        vec[0]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0};
        vec[1]  = '{8'h08, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 3'd3};
        vec[2]  = '{8'h08, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3};
        vec[3]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3};
        vec[4]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3};
        vec[5]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3};
        vec[6]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3};
        vec[7]  = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 3'd3};
        vec[8]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 3'd3};
        vec[9]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 3'd3};
        vec[10] = '{8'h04, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 3'd2};
        vec[11] = '{8'h04, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
        vec[12] = '{8'h44, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
        vec[13] = '{8'h44, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
        vec[14] = '{8'h44, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
        vec[15] = '{8'h44, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
        vec[16] = '{8'h44, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 3'd2};
        vec[17] = '{8'h44, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 3'd6};
        vec[18] = '{8'h44, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 3'd6};
        vec[19] = '{8'h44, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 3'd6};
        vec[20] = '{8'h04, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 3'd6};
        vec[21] = '{8'h04, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 3'd6};
        vec[22] = '{8'h04, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 3'd6};
        vec[23] = '{8'h04, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 3'd6};
        vec[24] = '{8'h04, 1'b1, 1'b1, 1'b0, 3'd6, 1'b1, 3'd6};
        vec[25] = '{8'h04, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 3'd2};
        vec[26] = '{8'h04, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 3'd2};
        vec[27] = '{8'h04, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
        vec[28] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
        vec[29] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
        vec[30] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
        vec[31] = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2};
        vec[32] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 3'd2};
        vec[33] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 3'd2};

        // Reset values
        step(2);
        chk("rst_ev_valid", int'(ev_valid), 0);
        chk("rst_ev_on",    int'(ev_on),    0);
        chk("rst_ev_note",  int'(ev_note),  0);
        chk("rst_active",   int'(active),   0);
        chk("rst_cur_note", int'(cur_note), 0);
        rst = 1'b0;
        step(1);

        // Cycle-exact: single note, last-note priority, fallback to held key
        for (int i = 0; i < 34; i++) begin
            key_level = vec[i].key;
            ev_ready  = vec[i].rdy;
            step(1);
            chk($sformatf("vec%0d_valid", i), int'(ev_valid), int'(vec[i].v));
            chk($sformatf("vec%0d_on",    i), int'(ev_on),    int'(vec[i].on));
            chk($sformatf("vec%0d_note",  i), int'(ev_note),  int'(vec[i].note));
            chk($sformatf("vec%0d_active",i), int'(active),   int'(vec[i].act));
            chk($sformatf("vec%0d_cur",   i), int'(cur_note), int'(vec[i].cur));
        end

        // Reset mid-event
        begin
            int x0;
            do_reset();
            key_level = 8'h08;
            step(1);
            chk("rme_offer", int'(ev_valid), 1);
            x0 = xfers;
            rst = 1'b1;
            #1;
            chk("rme_valid",  int'(ev_valid), 0);
            chk("rme_on",     int'(ev_on),    0);
            chk("rme_note",   int'(ev_note),  0);
            chk("rme_active", int'(active),   0);
            chk("rme_cur",    int'(cur_note), 0);
            key_level = '0;
            step(2);
            rst = 1'b0;
            step(3);
            chk("rme_no_xfer", xfers - x0, 0);
            chk("rme_idle_valid", int'(ev_valid), 0);
            key_level = 8'h20;
            step(1);
            chk("rme_idle_resp", int'(ev_valid), 1);
            chk("rme_idle_note", int'(ev_note), 5);
        end

        // Simultaneous press: lowest wins, the other comes from pend
        do_reset();
        key_level = 8'h22;
        step(1);
        wait_offer(1'b1, 1, "sim_on1");
        step(1);
        wait_offer(1'b0, 1, "sim_off1");
        step(1);
        chk("sim_gap", int'(ev_valid), 0);
        wait_offer(1'b1, 5, "sim_on5");
        step(1);
        chk("sim_cur5", int'(cur_note), 5);
        key_level = '0;
        wait_offer(1'b0, 5, "sim_off5");
        step(2);
        chk("sim_idle_active", int'(active), 0);

        // Backpressure during ON_EV with key 4 toggled
        begin
            int x0;
            logic ok;
            do_reset();
            ev_ready = 1'b0;
            key_level = 8'h10;
            step(1);
            x0 = xfers;
            ok = 1'b1;
            for (int i = 0; i < 20; i++) begin
                key_level = (i % 2 == 1) ? 8'h10 : 8'h00;
                step(1);
                if (!(ev_valid && ev_on && ev_note == 3'd4)) ok = 1'b0;
            end
            chk("bp_held_stable", int'(ok), 1);
            chk("bp_no_xfer", xfers - x0, 0);
            ev_ready = 1'b1;
            step(1);
            chk("bp_one_xfer", xfers - x0, 1);
            chk("bp_valid_drop", int'(ev_valid), 0);
            chk("bp_active", int'(active), 1);
            step(12);
            chk("bp_no_dup", xfers - x0, 1);
            key_level = '0;
            wait_offer(1'b0, 4, "bp_off4");
            step(1);
        end

        // Full release of two held keys: single note-off, no spurious note-on
        begin
            int x0;
            do_reset();
            x0 = xfers;
            key_level = 8'h81;
            step(1);
            wait_offer(1'b1, 0, "fr_on0");
            step(1);
            key_level = '0;
            wait_offer(1'b0, 0, "fr_off0");
            step(12);
            chk("fr_xfers", xfers - x0, 2);
            chk("fr_valid", int'(ev_valid), 0);
            chk("fr_active", int'(active), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
